// File: rtl/wired_icache_nway_pkg.sv
// Shared types for the wired N-way instruction cache: tag-entry layout and FSM state encoding.
// Used by wired_icache_nway and wired_icache_waysel.
package wired_icache_nway_pkg;

    localparam int unsigned TAG_W       = 20;
    localparam int unsigned TAG_ENTRY_W = TAG_W + 1;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

    typedef logic [2:0] icache_state_t;

    localparam icache_state_t S_FREE    = 3'd0;
    localparam icache_state_t S_REFILL  = 3'd1;
    localparam icache_state_t S_UNC     = 3'd2;
    localparam icache_state_t S_HANDLED = 3'd3;
    localparam icache_state_t S_DRAIN   = 3'd4;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/wired_icache_waysel.sv
// Tag compare and way-select mux; on multi-hit the hitting ways' data are ORed together.
module wired_icache_waysel
    import wired_icache_nway_pkg::*;
#(
    parameter int unsigned WAYS        = 4,
    parameter int unsigned FETCH_WIDTH = 2
) (
    input  logic [WAYS*TAG_ENTRY_W-1:0]    tags_i,
    input  logic [WAYS*FETCH_WIDTH*32-1:0] rdata_i,
    input  logic [TAG_W-1:0]               ptag_i,
    output logic                           hit_o,
    output logic [FETCH_WIDTH*32-1:0]      inst_o
);

    localparam int unsigned LINE_W = FETCH_WIDTH * 32;

    tag_entry_t entries [WAYS];

    for (genvar w = 0; w < WAYS; w++) begin : g_entry
        assign entries[w] = tag_entry_t'(tags_i[w*TAG_ENTRY_W +: TAG_ENTRY_W]);
    end

    always_comb begin
        hit_o  = 1'b0;
        inst_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (entries[w].valid && (entries[w].tag == ptag_i)) begin
                hit_o  = 1'b1;
                inst_o = inst_o | rdata_i[w*LINE_W +: LINE_W];
            end
        end
    end

endmodule

// File: rtl/wired_icache_nway.sv
// Two-stage (F1 lookup, F2 select/miss FSM) read-only N-way instruction cache front end.
// Optional hit/miss counters are built when WIRED_ICACHE_PERF_EN is defined.
module wired_icache_nway
    import wired_icache_nway_pkg::*;
#(
    parameter int unsigned WAYS        = 4,
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned PACKED_SIZE = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush_i,
    input  logic                           f_valid_i,
    output logic                           f_ready_o,
    input  logic [31:0]                    f_pc_i,
    input  logic [FETCH_WIDTH-1:0]         f_mask_i,
    input  logic [PACKED_SIZE-1:0]         f_pkg_i,
    input  logic [31:0]                    f1_paddr_i,
    input  logic                           f1_unc_i,
    output logic [11:0]                    p_addr_o,
    input  logic [WAYS*FETCH_WIDTH*32-1:0] p_rdata_i,
    input  logic [WAYS*TAG_ENTRY_W-1:0]    p_tag_i,
    output logic                           f_valid_o,
    input  logic                           f_ready_i,
    output logic [31:0]                    f_pc_o,
    output logic [FETCH_WIDTH-1:0]         f_mask_o,
    output logic [PACKED_SIZE-1:0]         f_pkg_o,
    output logic [FETCH_WIDTH*32-1:0]      f_inst_o,
    output logic                           bus_valid_o,
    input  logic                           bus_ready_i,
    output logic [31:0]                    bus_addr_o,
    output logic                           bus_unc_o,
    input  logic [FETCH_WIDTH*32-1:0]      bus_rdata_i,
    output logic [31:0]                    perf_hit_o,
    output logic [31:0]                    perf_miss_o
);

    localparam int unsigned LINE_W   = FETCH_WIDTH * 32;
    localparam int unsigned OFF_BITS = $clog2(FETCH_WIDTH * 4);

    icache_state_t state_q, state_d;

    logic                   f1_valid_q;
    logic [31:0]            f1_pc_q;
    logic [FETCH_WIDTH-1:0] f1_mask_q;
    logic [PACKED_SIZE-1:0] f1_pkg_q;

    logic                   f2_valid_q;
    logic [31:0]            f2_pc_q;
    logic [FETCH_WIDTH-1:0] f2_mask_q;
    logic [PACKED_SIZE-1:0] f2_pkg_q;
    logic                   f2_hit_q;
    logic                   f2_unc_q;
    logic [LINE_W-1:0]      f2_inst_q;
    logic [31:OFF_BITS]     f2_line_q;

    logic [31:OFF_BITS]     bus_addr_q;
    logic                   bus_unc_q;
    logic [LINE_W-1:0]      fill_data_q;

    logic              f1_hit;
    logic [LINE_W-1:0] f1_inst;
    logic              advance;
    logic              f2_mask_zero;
    logic              f2_hit_ok;
    logic              free_pass;
    logic              f2_miss;
    logic              miss_start;
    logic              in_bus_req;
    logic              unused_paddr_bits;

    // Sub-line address bits are irrelevant: the bus request is always line aligned.
    assign unused_paddr_bits = ^f1_paddr_i[OFF_BITS-1:0];

    wired_icache_waysel #(
        .WAYS        (WAYS),
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_waysel (
        .tags_i  (p_tag_i),
        .rdata_i (p_rdata_i),
        .ptag_i  (f1_paddr_i[31:12]),
        .hit_o   (f1_hit),
        .inst_o  (f1_inst)
    );

    always_comb begin
        f2_mask_zero = (f2_mask_q == '0);
        // Uncached requests must go to the bus even if a stale line happens to match.
        f2_hit_ok    = f2_hit_q && !f2_unc_q;
        free_pass    = (state_q == S_FREE) && f2_valid_q && (f2_mask_zero || f2_hit_ok);
        f2_miss      = (state_q == S_FREE) && f2_valid_q && !f2_mask_zero && !f2_hit_ok;
        miss_start   = f2_miss && !flush_i;
        in_bus_req   = (state_q == S_REFILL) || (state_q == S_UNC);

        f_valid_o = free_pass || (state_q == S_HANDLED);
        if (state_q == S_HANDLED) begin
            f_inst_o = fill_data_q;
        end else if (f2_mask_zero) begin
            f_inst_o = '0;
        end else begin
            f_inst_o = f2_inst_q;
        end

        advance   = (state_q != S_DRAIN) && (!f2_valid_q || (f_valid_o && f_ready_i));
        f_ready_o = advance;
        // While stalled, keep re-reading the F1 index so its SRAM data stays current.
        p_addr_o  = advance ? f_pc_i[11:0] : f1_pc_q[11:0];

        bus_valid_o = in_bus_req || (state_q == S_DRAIN);
        bus_addr_o  = {bus_addr_q, {OFF_BITS{1'b0}}};
        bus_unc_o   = bus_unc_q;

        f_pc_o   = f2_pc_q;
        f_mask_o = f2_mask_q;
        f_pkg_o  = f2_pkg_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FREE: begin
                if (miss_start) begin
                    state_d = f2_unc_q ? S_UNC : S_REFILL;
                end
            end
            S_REFILL, S_UNC: begin
                if (bus_ready_i) begin
                    state_d = flush_i ? S_FREE : S_HANDLED;
                end else if (flush_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_HANDLED: begin
                if (flush_i || f_ready_i) begin
                    state_d = S_FREE;
                end
            end
            S_DRAIN: begin
                if (bus_ready_i) begin
                    state_d = S_FREE;
                end
            end
            default: state_d = S_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_FREE;
            f1_valid_q <= 1'b0;
            f2_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (flush_i) begin
                f1_valid_q <= 1'b0;
                f2_valid_q <= 1'b0;
            end else if (advance) begin
                f1_valid_q <= f_valid_i;
                f2_valid_q <= f1_valid_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            f1_pc_q   <= f_pc_i;
            f1_mask_q <= f_mask_i;
            f1_pkg_q  <= f_pkg_i;
            f2_pc_q   <= f1_pc_q;
            f2_mask_q <= f1_mask_q;
            f2_pkg_q  <= f1_pkg_q;
            f2_hit_q  <= f1_hit;
            f2_unc_q  <= f1_unc_i;
            f2_inst_q <= f1_inst;
            f2_line_q <= f1_paddr_i[31:OFF_BITS];
        end
        if (miss_start) begin
            bus_addr_q <= f2_line_q;
            bus_unc_q  <= f2_unc_q;
        end
        if (in_bus_req && bus_ready_i) begin
            fill_data_q <= bus_rdata_i;
        end
    end

`ifdef WIRED_ICACHE_PERF_EN
    logic [31:0] perf_hit_q;
    logic [31:0] perf_miss_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_hit_q  <= '0;
            perf_miss_q <= '0;
        end else begin
            if (free_pass && !f2_mask_zero && f_ready_i) begin
                perf_hit_q <= sat_inc(perf_hit_q);
            end
            if (miss_start) begin
                perf_miss_q <= sat_inc(perf_miss_q);
            end
        end
    end

    assign perf_hit_o  = perf_hit_q;
    assign perf_miss_o = perf_miss_q;
`else
    assign perf_hit_o  = '0;
    assign perf_miss_o = '0;
`endif

endmodule

// File: tb/tb_wired_icache_nway.sv
// Directed bench for wired_icache_nway with a result scoreboard and a simple SRAM/translation model.
module tb_wired_icache_nway;

    localparam int unsigned WAYS = 4;
    localparam int unsigned FW   = 2;
    localparam int unsigned PS   = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush_i;
    logic              f_valid_i;
    logic              f_ready_o;
    logic [31:0]       f_pc_i;
    logic [FW-1:0]     f_mask_i;
    logic [PS-1:0]     f_pkg_i;
    logic [31:0]       f1_paddr_i;
    logic              f1_unc_i;
    logic [11:0]       p_addr_o;
    logic [WAYS*FW*32-1:0] p_rdata_i;
    logic [WAYS*21-1:0]    p_tag_i;
    logic              f_valid_o;
    logic              f_ready_i;
    logic [31:0]       f_pc_o;
    logic [FW-1:0]     f_mask_o;
    logic [PS-1:0]     f_pkg_o;
    logic [FW*32-1:0]  f_inst_o;
    logic              bus_valid_o;
    logic              bus_ready_i;
    logic [31:0]       bus_addr_o;
    logic              bus_unc_o;
    logic [FW*32-1:0]  bus_rdata_i;
    logic [31:0]       perf_hit_o;
    logic [31:0]       perf_miss_o;

    always #5 clk = ~clk;

    wired_icache_nway #(
        .WAYS        (WAYS),
        .FETCH_WIDTH (FW),
        .PACKED_SIZE (PS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .f_valid_i   (f_valid_i),
        .f_ready_o   (f_ready_o),
        .f_pc_i      (f_pc_i),
        .f_mask_i    (f_mask_i),
        .f_pkg_i     (f_pkg_i),
        .f1_paddr_i  (f1_paddr_i),
        .f1_unc_i    (f1_unc_i),
        .p_addr_o    (p_addr_o),
        .p_rdata_i   (p_rdata_i),
        .p_tag_i     (p_tag_i),
        .f_valid_o   (f_valid_o),
        .f_ready_i   (f_ready_i),
        .f_pc_o      (f_pc_o),
        .f_mask_o    (f_mask_o),
        .f_pkg_o     (f_pkg_o),
        .f_inst_o    (f_inst_o),
        .bus_valid_o (bus_valid_o),
        .bus_ready_i (bus_ready_i),
        .bus_addr_o  (bus_addr_o),
        .bus_unc_o   (bus_unc_o),
        .bus_rdata_i (bus_rdata_i),
        .perf_hit_o  (perf_hit_o),
        .perf_miss_o (perf_miss_o)
    );

    // SRAM model: data for way w / slot s encodes w, s and the index; tags are index independent.
    logic [20:0] tag_mem [WAYS];
    logic [11:0] sram_addr_q;
    logic [31:0] xl_pc_q;
    logic        xl_unc_q;
    logic        req_unc;

    function automatic logic [31:0] sram_word(input int w, input int s, input logic [11:0] a);
        return 32'hD000_0000 | (32'(w) << 16) | (32'(s) << 12) | {20'd0, a};
    endfunction

    function automatic logic [63:0] exp_line(input logic [WAYS-1:0] hm, input logic [11:0] a);
        logic [63:0] r;
        r = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hm[w]) begin
                for (int s = 0; s < FW; s++) r[s*32 +: 32] = r[s*32 +: 32] | sram_word(w, s, a);
            end
        end
        return r;
    endfunction

    always @(posedge clk) sram_addr_q <= p_addr_o;

    always_comb begin
        p_rdata_i = '0;
        p_tag_i   = '0;
        for (int w = 0; w < WAYS; w++) begin
            p_tag_i[w*21 +: 21] = tag_mem[w];
            for (int s = 0; s < FW; s++) p_rdata_i[(w*FW+s)*32 +: 32] = sram_word(w, s, sram_addr_q);
        end
    end

    // Identity translation, presented the cycle after acceptance.
    always @(posedge clk) begin
        if (f_valid_i && f_ready_o) begin
            xl_pc_q  <= f_pc_i;
            xl_unc_q <= req_unc;
        end
    end
    assign f1_paddr_i = xl_pc_q;
    assign f1_unc_i   = xl_unc_q;

    typedef struct {
        logic [31:0]   pc;
        logic [FW-1:0] mask;
        logic [PS-1:0] pkg;
        logic [63:0]   inst;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_chk = 0;
    int   valid_seen = 0;
    bit   bus_seen = 1'b0;
    int   exp_hit = 0;
    int   exp_miss = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Sample outputs on the falling edge, then move to just after the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (bus_valid_o) bus_seen = 1'b1;
        if (f_valid_o) valid_seen++;
        if (f_valid_o && f_ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 64'(f_valid_o), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("res_pc", 64'(f_pc_o), 64'(e.pc));
                chk("res_mask", 64'(f_mask_o), 64'(e.mask));
                chk("res_pkg", 64'(f_pkg_o), 64'(e.pkg));
                chk("res_inst", 64'(f_inst_o), e.inst);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [FW-1:0] m, input logic [PS-1:0] pkg,
                        input logic [63:0] inst);
        exp_t e;
        e.pc = pc; e.mask = m; e.pkg = pkg; e.inst = inst;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [31:0] pc, input logic [FW-1:0] m, input logic unc,
                         input logic [PS-1:0] pkg);
        int n;
        f_pc_i = pc; f_mask_i = m; f_pkg_i = pkg; req_unc = unc; f_valid_i = 1'b1;
        n = 0;
        while (!f_ready_o && n < 50) begin tick(); n++; end
        chk("accept", 64'(f_ready_o), 64'd1);
        tick();
        f_valid_i = 1'b0;
    endtask

    task automatic wait_bus();
        int n;
        n = 0;
        while (!bus_valid_o && n < 20) begin tick(); n++; end
        chk("bus_req", 64'(bus_valid_o), 64'd1);
    endtask

    task automatic pulse_bus(input logic [63:0] data);
        bus_rdata_i = data; bus_ready_i = 1'b1;
        tick();
        bus_ready_i = 1'b0;
    endtask

    task automatic drain_sb();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin tick(); n++; end
        chk("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic set_tags(input logic [WAYS-1:0] hm, input logic [19:0] t);
        for (int w = 0; w < WAYS; w++) tag_mem[w] = hm[w] ? {1'b1, t} : 21'd0;
    endtask

    task automatic do_hit(input logic [31:0] pc, input logic [WAYS-1:0] hm, input logic [PS-1:0] pkg);
        set_tags(hm, pc[31:12]);
        push(pc, 2'b11, pkg, exp_line(hm, pc[11:0]));
        issue(pc, 2'b11, 1'b0, pkg);
        drain_sb();
        exp_hit++;
    endtask

    task automatic do_miss(input logic [31:0] pc, input logic unc, input logic [FW-1:0] m,
                           input logic [63:0] data);
        set_tags('0, 20'h0);
        push(pc, m, 32'hC0DE_0000 | pc[15:0], data);
        issue(pc, m, unc, 32'hC0DE_0000 | pc[15:0]);
        wait_bus();
        chk("refill_no_valid", 64'(f_valid_o), 64'd0);
        chk("bus_addr", 64'(bus_addr_o), 64'({pc[31:3], 3'b000}));
        chk("bus_unc", 64'(bus_unc_o), 64'(unc));
        tick(); tick();
        chk("bus_addr_hold", 64'(bus_addr_o), 64'({pc[31:3], 3'b000}));
        pulse_bus(data);
        exp_miss++;
    endtask

    task automatic check_perf();
`ifdef WIRED_ICACHE_PERF_EN
        chk("perf_hit", 64'(perf_hit_o), 64'(exp_hit));
        chk("perf_miss", 64'(perf_miss_o), 64'(exp_miss));
`else
        chk("perf_hit_tied", 64'(perf_hit_o), 64'd0);
        chk("perf_miss_tied", 64'(perf_miss_o), 64'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; f_valid_i = 1'b0; f_pc_i = '0; f_mask_i = '0;
        f_pkg_i = '0; req_unc = 1'b0; f_ready_i = 1'b1; bus_ready_i = 1'b0; bus_rdata_i = '0;
        set_tags('0, 20'h0);
        repeat (3) tick();
        chk("rst_f_valid", 64'(f_valid_o), 64'd0);
        chk("rst_bus_valid", 64'(bus_valid_o), 64'd0);
        check_perf();
        rst_n = 1'b1;
        tick();

        // Hit in way 2, two cycles from acceptance to result, no bus traffic.
        bus_seen = 1'b0;
        set_tags(4'b0100, 20'h12345);
        push(32'h1234_5008, 2'b11, 32'hA5A5_0001, exp_line(4'b0100, 12'h008));
        issue(32'h1234_5008, 2'b11, 1'b0, 32'hA5A5_0001);
        chk("hit_f1_empty", 64'(f_valid_o), 64'd0);
        tick();
        chk("hit_latency", 64'(f_valid_o), 64'd1);
        chk("hit_inst_now", 64'(f_inst_o), exp_line(4'b0100, 12'h008));
        drain_sb();
        chk("hit_no_bus", 64'(bus_seen), 64'd0);
        exp_hit++;

        // Cacheable miss delivered from the bus.
        do_miss(32'h1234_5008, 1'b0, 2'b11, 64'hAABBCCDD_11223344);
        chk("handled_valid", 64'(f_valid_o), 64'd1);
        chk("handled_inst", 64'(f_inst_o), 64'hAABBCCDD_11223344);
        drain_sb();

        // Uncached miss with a back-pressuring consumer; unaligned PC.
        f_ready_i = 1'b0;
        do_miss(32'h0001_0014, 1'b1, 2'b01, 64'h0123_4567_89AB_CDEF);
        for (int i = 0; i < 3; i++) begin
            chk("unc_hold_valid", 64'(f_valid_o), 64'd1);
            chk("unc_hold_inst", 64'(f_inst_o), 64'h0123_4567_89AB_CDEF);
            tick();
        end
        f_ready_i = 1'b1;
        drain_sb();
        chk("unc_released", 64'(f_valid_o), 64'd0);
        check_perf();

        // Flush during refill: drain the outstanding bus response.
        set_tags('0, 20'h0);
        issue(32'h1234_5010, 2'b11, 1'b0, 32'h0);
        wait_bus();
        exp_miss++;
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        valid_seen = 0;
        for (int i = 0; i < 3; i++) begin
            chk("drain_ready_low", 64'(f_ready_o), 64'd0);
            chk("drain_bus_held", 64'(bus_valid_o), 64'd1);
            tick();
        end
        chk("drain_ready_last", 64'(f_ready_o), 64'd0);
        pulse_bus(64'hDEAD_DEAD_DEAD_DEAD);
        chk("drain_done_ready", 64'(f_ready_o), 64'd1);
        chk("drain_bus_idle", 64'(bus_valid_o), 64'd0);
        tick(); tick();
        chk("flush_no_result", 64'(valid_seen), 64'd0);

        // Flush coinciding with the bus response discards the data.
        issue(32'h1234_5018, 2'b11, 1'b0, 32'h0);
        wait_bus();
        exp_miss++;
        valid_seen = 0;
        flush_i = 1'b1;
        pulse_bus(64'h5555_5555_5555_5555);
        flush_i = 1'b0;
        chk("flush_rdy_bus_idle", 64'(bus_valid_o), 64'd0);
        tick(); tick();
        chk("flush_rdy_no_result", 64'(valid_seen), 64'd0);

        // Flush while the refilled result is waiting.
        f_ready_i = 1'b0;
        issue(32'h1234_5020, 2'b11, 1'b0, 32'h0);
        wait_bus();
        pulse_bus(64'h7777_7777_7777_7777);
        exp_miss++;
        chk("handled_wait", 64'(f_valid_o), 64'd1);
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        chk("handled_flushed", 64'(f_valid_o), 64'd0);
        f_ready_i = 1'b1;
        check_perf();

        // Reset mid-refill abandons the bus request.
        issue(32'h1234_5028, 2'b11, 1'b0, 32'h0);
        wait_bus();
        rst_n = 1'b0; tick();
        chk("rst_mid_bus", 64'(bus_valid_o), 64'd0);
        chk("rst_mid_valid", 64'(f_valid_o), 64'd0);
        rst_n = 1'b1;
        exp_hit = 0; exp_miss = 0;
        tick();
        chk("rst_no_drain", 64'(bus_valid_o), 64'd0);
        check_perf();

        // All-zero mask passes through without a bus access.
        bus_seen = 1'b0;
        set_tags('0, 20'h0);
        push(32'h1234_5008, 2'b00, 32'h0000_BEEF, 64'd0);
        issue(32'h1234_5008, 2'b00, 1'b0, 32'h0000_BEEF);
        drain_sb();
        chk("mask0_no_bus", 64'(bus_seen), 64'd0);

        // Multi-hit, then two more hits and two misses for the counters.
        do_hit(32'h1234_5008, 4'b1001, 32'h1111_0000);
        do_hit(32'h2000_0100, 4'b0010, 32'h2222_0000);
        do_hit(32'h3000_0FF8, 4'b1000, 32'h3333_0000);
        do_miss(32'h4000_0020, 1'b0, 2'b11, 64'h0BAD_F00D_CAFE_BABE);
        drain_sb();
        do_miss(32'h5000_0FF4, 1'b1, 2'b10, 64'h1357_9BDF_2468_ACE0);
        drain_sb();
        check_perf();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wired_icache_nway.md
WIRED_ICACHE_NWAY -- requirements
Module: wired_icache_nway

Interface
REQ-001 SHALL have parameters: WAYS, default 4, associativity (2, 4 or 8); FETCH_WIDTH, default 2, instructions per fetch (1, 2 or 4); PACKED_SIZE, default 32, sideband width.
REQ-002 SHALL have ports (name, direction, width, meaning):
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
flush_i  in  1  kill all in-flight fetches
f_valid_i  in  1  fetch request valid
f_ready_o  out  1  request accepted
f_pc_i  in  32  fetch virtual PC
f_mask_i  in  FETCH_WIDTH  per-slot valid mask
f_pkg_i  in  PACKED_SIZE  sideband carried unchanged
f1_paddr_i  in  32  physical address of the F1 request, valid one cycle after acceptance
f1_unc_i  in  1  F1 request is uncached
p_addr_o  out  12  SRAM index/offset
p_rdata_i  in  WAYS*FETCH_WIDTH*32  per-way data, one cycle after p_addr_o
p_tag_i  in  WAYS*21  per-way {valid, tag[19:0]}
f_valid_o  out  1  fetch result valid
f_ready_i  in  1  consumer ready
f_pc_o  out  32  result PC
f_mask_o  out  FETCH_WIDTH  result mask
f_pkg_o  out  PACKED_SIZE  result sideband
f_inst_o  out  FETCH_WIDTH*32  instructions
bus_valid_o  out  1  bus request
bus_ready_i  in  1  bus response complete, one-cycle pulse
bus_addr_o  out  32  request address, aligned to FETCH_WIDTH*4
bus_unc_o  out  1  uncached load; 0 means refill-allocate
bus_rdata_i  in  FETCH_WIDTH*32  response data
perf_hit_o  out  32  hit count (macro only)
perf_miss_o  out  32  miss count (macro only)

Function
REQ-003 SHALL run as a two-stage pipe: F1 (SRAM read, translation) and F2 (hit select or miss FSM).
REQ-004 SHALL advance when F2 is empty or its result is taken; f_ready_o = advance; F1 is captured only when advancing.
REQ-005 SHALL drive p_addr_o = f_pc_i[11:0] when advancing, else the F1 PC[11:0], so stalled F1 data is re-read every cycle; no skid buffer.
REQ-006 SHALL declare way w hit when tag valid and tag == f1_paddr_i[31:12]; on multi-hit, f_inst_o is the OR of the hitting ways.
REQ-007 SHALL use FSM states S_FREE, S_REFILL, S_UNC, S_HANDLED, S_DRAIN.
REQ-008 S_FREE SHALL do the following:
- F2 valid and hit: f_valid_o=1 in the same cycle with the hit way's data.
- F2 valid, mask nonzero and miss: go to S_REFILL, or to S_UNC if uncached; f_valid_o=0.
- Mask all-zero: pass through with f_inst_o=0 and no bus access.
REQ-009 S_REFILL/S_UNC SHALL hold bus_valid_o=1 with constant bus_addr_o and bus_unc_o; on bus_ready_i, capture bus_rdata_i and go to S_HANDLED.
REQ-010 S_HANDLED SHALL assert f_valid_o with the captured data; on f_ready_i, go to S_FREE.
REQ-011 flush_i SHALL clear F1/F2 valid in the next cycle:
- In S_HANDLED: go to S_FREE.
- In S_REFILL/S_UNC without a same-cycle bus_ready_i: go to S_DRAIN.
- Same-cycle flush and bus_ready_i: go to S_FREE and discard the data.
REQ-012 S_DRAIN SHALL keep bus_valid_o=1 until bus_ready_i, discard the data, and return to S_FREE; f_ready_o=0 while draining.
REQ-013 SHALL NOT write tags or data; the refill side updates SRAM.
REQ-014 After a refill, SHALL deliver the bus data directly and never re-look-up F2.

Reset
REQ-015 On rst_n=0, SHALL set FSM=S_FREE, F1/F2 valid=0, f_valid_o=0, bus_valid_o=0, and perf counters=0.
REQ-016 Reset mid-refill SHALL abandon the bus transaction without draining.

Configuration
REQ-017 With WIRED_ICACHE_PERF_EN defined:
- perf_hit_o increments on each accepted hit result.
- perf_miss_o increments on each entry to S_REFILL or S_UNC.
- Both saturate at 32'hFFFFFFFF.
REQ-018 Without WIRED_ICACHE_PERF_EN, perf outputs SHALL be tied to 0 and no counter flops exist.

Structure
REQ-019 SHALL keep the FSM state enum and the tag-entry typedef {valid, tag[19:0]} in the shared wired package.
REQ-020 SHALL place the hit/way-select mux in sub-module wired_icache_waysel (parameters WAYS, FETCH_WIDTH).

Verification
REQ-021 Hit: tag way2 = 0x12345, paddr 0x12345008, f_ready_i=1 -> f_valid_o after 2 cycles, f_inst_o = way2 data, no bus_valid_o.
REQ-022 Miss: all tags invalid -> bus_valid_o, bus_addr_o=0x12345008, bus_unc_o=0; bus_ready_i with rdata 0xAABBCCDD_11223344 -> f_inst_o equals it in S_HANDLED.
REQ-023 Uncached with f_ready_i held 0 for 3 cycles -> f_valid_o held with stable data, released on f_ready_i.
REQ-024 Flush in S_REFILL, bus_ready_i 4 cycles later -> no f_valid_o, f_ready_o=0 until the drain completes.
REQ-025 Mask 2'b00 -> passthrough, f_inst_o=0, no bus request.
REQ-026 With WIRED_ICACHE_PERF_EN: 3 hits and 2 misses -> perf_hit_o=3, perf_miss_o=2.
